branch_hazard_controller: RTL and testbench
===========================================

BRANCH_HAZARD_CONTROLLER -- requirements
Module: branch_hazard_controller

Interface
REQ-001 SHALL have parameter NB_REG, default 5, register-address width.
REQ-002 SHALL have parameter NB_COUNT, default 16, stall-counter width.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clock_i, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset_n_i, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port enable_i, input, 1 bit: pipeline advance enable from the debug unit.
REQ-007 SHALL have port ID_branch_i, input, 1 bit: the ID-stage instruction is BEQ/BNE.
REQ-008 SHALL have port ID_taken_i, input, 1 bit: the ID comparator result after forwarding.
REQ-009 SHALL have ports ID_rs_i and ID_rt_i, input, NB_REG bits each: the branch source registers.
REQ-010 SHALL have ports EX_write_reg_i (input, NB_REG), EX_reg_write_i (input, 1) and EX_mem_read_i (input, 1): the destination, write enable and load flag of the EX-stage instruction.
REQ-011 SHALL have ports MEM_write_reg_i (input, NB_REG), MEM_reg_write_i (input, 1) and MEM_mem_read_i (input, 1): the same three fields for the MEM-stage instruction.
REQ-012 SHALL have port stall_o, output, 1 bit: hold PC and IF/ID.
REQ-013 SHALL have port bubble_o, output, 1 bit: insert a NOP into ID/EX.
REQ-014 SHALL have port flush_o, output, 1 bit: clear IF/ID when a taken branch resolves.
REQ-015 SHALL have port stall_count_o, output, NB_COUNT bits: total branch-stall cycles since reset.

Function
REQ-016 SHALL define a hazard as an operand that equals a destination register, where that destination is non-zero and its write enable is 1.
REQ-017 SHALL treat register 0 as never hazardous.
REQ-018 SHALL implement states IDLE, STALL_2 and STALL_1.
REQ-019 SHALL, in IDLE with ID_branch_i=1 and an EX hazard with EX_mem_read_i=1, go to STALL_2.
REQ-020 SHALL, in IDLE with ID_branch_i=1 and either an EX ALU hazard (EX_mem_read_i=0) or a MEM hazard with MEM_mem_read_i=1, go to STALL_1.
REQ-021 SHALL give an EX hazard priority over a MEM hazard.
REQ-022 SHALL treat a MEM hazard from a non-load as no stall, because the existing branch forwarding path covers it.
REQ-023 SHALL always go from STALL_2 to STALL_1, and from STALL_1 to IDLE; IDLE then re-evaluates.
REQ-024 SHALL assert stall_o and bubble_o combinationally, in the same cycle, whenever the next-state decision or the current state is non-IDLE.
REQ-025 SHALL leave the pipeline free-running from IDLE when there is no branch or no hazard.
REQ-026 SHALL assert flush_o for exactly one cycle when in IDLE with ID_branch_i=1, no hazard, ID_taken_i=1 and enable_i=1.
REQ-027 SHALL never assert flush_o together with stall_o.
REQ-028 SHALL, while enable_i=0, hold the state and counter and force flush_o=0; stall_o and bubble_o keep reflecting the current state.
REQ-029 SHALL increment stall_count_o on every enabled cycle with stall_o=1.
REQ-030 SHALL saturate stall_count_o at all-ones and never wrap.
REQ-031 SHALL give the stall sequence total latency of 2 cycles for load→branch and 1 cycle for ALU→branch or load-in-MEM→branch.

Reset
REQ-032 SHALL, with reset_n_i=0 at a rising edge, set the state to IDLE and stall_count_o to 0.
REQ-033 SHALL force stall_o, bubble_o and flush_o to 0 while reset_n_i=0.
REQ-034 SHALL, on reset mid-stall, abort the sequence: IDLE after the edge, with no residual stall cycle.

Configuration
REQ-035 SHALL, with macro BRANCH_STALL_COUNTER_EN defined, implement the saturating counter of REQ-029/030.
REQ-036 SHALL, without the macro, keep port stall_count_o, drive it constant 0 and infer no counter flops.

Structure
REQ-037 SHALL put the state encoding (IDLE=2'd0, STALL_2=2'd1, STALL_1=2'd2) and the NB_REG and NB_COUNT defaults in shared package mips_pkg.
REQ-038 SHALL place the combinational hazard comparison in one sub-module, branch_hazard_detect, with outputs ex_alu_hz, ex_load_hz and mem_load_hz.
REQ-039 SHALL keep the FSM and the counter in the top module.

Verification
REQ-040 SHALL verify: EX lw $3, ID beq $3,$4, taken → stall_o=1 for 2 cycles, bubble_o=1 both cycles, then flush_o=1 for 1 cycle, stall_count_o=2.
REQ-041 SHALL verify: EX add $5, ID bne $5,$0, not taken → stall_o=1 for 1 cycle, flush_o=0 throughout.
REQ-042 SHALL verify: EX lw $0, ID beq $0,$0 → no stall, and flush_o=1 immediately.
REQ-043 SHALL verify: MEM add $7 (non-load), ID beq $7,$1 → no stall; MEM lw $7 instead → 1 stall cycle.
REQ-044 SHALL verify: reset_n_i=0 asserted in STALL_2 → next cycle IDLE, all outputs 0, stall_count_o=0.
REQ-045 SHALL verify: enable_i=0 for 3 cycles during STALL_1 → state and counter held, flush_o=0; sequence completes after enable_i returns to 1.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS branch hazard logic.
//   - Default register-address and stall-counter widths.
//   - State encoding of the branch stall sequencer.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int NB_REG_DEF   = 5;
    localparam int NB_COUNT_DEF = 16;

    // The state encoding is fixed so that debug tooling can decode the state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL_2 = 2'd1,
        STALL_1 = 2'd2
    } bhc_state_e;

    // A destination register only creates a hazard if it is written and is
    // not $0, because $0 always reads as zero.
    function automatic logic regHazard(input logic [NB_REG_DEF-1:0] src,
                                       input logic [NB_REG_DEF-1:0] dst,
                                       input logic                  we);
        return we && (dst != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// ---------------------------------------------------------------------------
// branch_hazard_detect
// Combinational comparison of the ID-stage branch source registers against
// the destinations of the instructions in EX and MEM.
//
// Ports:
//   id_rs_i, id_rt_i      branch source registers
//   ex_write_reg_i        EX destination register
//   ex_reg_write_i        EX register write enable
//   ex_mem_read_i         EX instruction is a load
//   mem_write_reg_i       MEM destination register
//   mem_reg_write_i       MEM register write enable
//   mem_mem_read_i        MEM instruction is a load
//   ex_alu_hz             branch depends on an ALU result still in EX
//   ex_load_hz            branch depends on a load still in EX
//   mem_load_hz           branch depends on a load in MEM
// ---------------------------------------------------------------------------
module branch_hazard_detect
    import mips_pkg::*;
#(
    parameter int NB_REG = NB_REG_DEF
) (
    input  logic [NB_REG-1:0] id_rs_i,
    input  logic [NB_REG-1:0] id_rt_i,
    input  logic [NB_REG-1:0] ex_write_reg_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [NB_REG-1:0] mem_write_reg_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_mem_read_i,
    output logic              ex_alu_hz,
    output logic              ex_load_hz,
    output logic              mem_load_hz
);

    logic exValid;
    logic memValid;
    logic exMatch;
    logic memMatch;

    assign exValid  = ex_reg_write_i && (ex_write_reg_i != '0);
    assign memValid = mem_reg_write_i && (mem_write_reg_i != '0);

    assign exMatch  = exValid && ((id_rs_i == ex_write_reg_i) || (id_rt_i == ex_write_reg_i));
    assign memMatch = memValid && ((id_rs_i == mem_write_reg_i) || (id_rt_i == mem_write_reg_i));

    // A non-load in MEM is already covered by the branch forwarding path,
    // so only a load there is reported.
    assign ex_alu_hz   = exMatch && !ex_mem_read_i;
    assign ex_load_hz  = exMatch && ex_mem_read_i;
    assign mem_load_hz = memMatch && mem_mem_read_i;

endmodule

// File: rtl/branch_hazard_controller.sv
// ---------------------------------------------------------------------------
// branch_hazard_controller
// Stalls a branch resolved in ID until its source operands can be forwarded,
// and flushes IF/ID when a branch is taken.
//
// Optional feature: define BRANCH_STALL_COUNTER_EN to build a saturating
// counter of branch-stall cycles on stall_count_o; otherwise that port is 0.
//
// Ports:
//   clock_i          rising-edge clock
//   reset_n_i        synchronous active-low reset
//   enable_i         pipeline advance enable from the debug unit
//   ID_branch_i      ID instruction is BEQ/BNE
//   ID_taken_i       ID comparator result after forwarding
//   ID_rs_i/ID_rt_i  branch source registers
//   EX_*             destination, write enable, load flag of EX instruction
//   MEM_*            destination, write enable, load flag of MEM instruction
//   stall_o          hold PC and IF/ID
//   bubble_o         insert a NOP into ID/EX
//   flush_o          clear IF/ID for a resolved taken branch
//   stall_count_o    branch-stall cycles since reset (saturating)
// ---------------------------------------------------------------------------
module branch_hazard_controller
    import mips_pkg::*;
#(
    parameter int NB_REG   = NB_REG_DEF,
    parameter int NB_COUNT = NB_COUNT_DEF
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                enable_i,
    input  logic                ID_branch_i,
    input  logic                ID_taken_i,
    input  logic [NB_REG-1:0]   ID_rs_i,
    input  logic [NB_REG-1:0]   ID_rt_i,
    input  logic [NB_REG-1:0]   EX_write_reg_i,
    input  logic                EX_reg_write_i,
    input  logic                EX_mem_read_i,
    input  logic [NB_REG-1:0]   MEM_write_reg_i,
    input  logic                MEM_reg_write_i,
    input  logic                MEM_mem_read_i,
    output logic                stall_o,
    output logic                bubble_o,
    output logic                flush_o,
    output logic [NB_COUNT-1:0] stall_count_o
);

    bhc_state_e state_q;
    bhc_state_e state_d;
    bhc_state_e nextState;

    logic exAluHz;
    logic exLoadHz;
    logic memLoadHz;

    branch_hazard_detect #(
        .NB_REG (NB_REG)
    ) u_detect (
        .id_rs_i         (ID_rs_i),
        .id_rt_i         (ID_rt_i),
        .ex_write_reg_i  (EX_write_reg_i),
        .ex_reg_write_i  (EX_reg_write_i),
        .ex_mem_read_i   (EX_mem_read_i),
        .mem_write_reg_i (MEM_write_reg_i),
        .mem_reg_write_i (MEM_reg_write_i),
        .mem_mem_read_i  (MEM_mem_read_i),
        .ex_alu_hz       (exAluHz),
        .ex_load_hz      (exLoadHz),
        .mem_load_hz     (memLoadHz)
    );

    // Next-state and output decode.  Stall is raised for every cycle whose
    // next state is a stall state, so a load gives two held cycles (IDLE and
    // STALL_2) and an ALU or MEM-load dependency gives one (IDLE); STALL_1 is
    // the release cycle in which the operand becomes forwardable.  While the
    // debug unit freezes the pipeline the state is held, so stall keeps
    // following the held state.
    always_comb begin
        nextState = IDLE;
        unique case (state_q)
            IDLE: begin
                if (ID_branch_i) begin
                    if (exLoadHz) begin
                        nextState = STALL_2;
                    end else if (exAluHz || memLoadHz) begin
                        nextState = STALL_1;
                    end
                end
            end
            STALL_2: nextState = STALL_1;
            STALL_1: nextState = IDLE;
            default: nextState = IDLE;
        endcase

        state_d  = enable_i ? nextState : state_q;
        stall_o  = reset_n_i && (state_d != IDLE);
        bubble_o = stall_o;
        flush_o  = reset_n_i && enable_i && (state_q == IDLE) && (nextState == IDLE)
                   && ID_branch_i && ID_taken_i;
    end

    // State register; reset aborts any sequence in progress.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef BRANCH_STALL_COUNTER_EN
    logic [NB_COUNT-1:0] count_q;
    logic [NB_COUNT-1:0] count_d;

    // Count enabled stall cycles, sticking at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (enable_i && stall_o && (count_q != '1)) begin
            count_d = count_q + NB_COUNT'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stall_count_o = count_q;
`else
    assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_controller
// Self-checking bench: directed scenarios plus randomized traffic, compared
// each cycle against a queue-based reference model of the stall sequence.
// Build with BRANCH_STALL_COUNTER_EN defined to exercise the counter.
// ---------------------------------------------------------------------------
module tb_branch_hazard_controller;

    localparam int NB_REG   = 5;
    localparam int NB_COUNT = 4;
    localparam int CNT_MAX  = (1 << NB_COUNT) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetN;
    logic                enable;
    logic                branch;
    logic                taken;
    logic [NB_REG-1:0]   rs;
    logic [NB_REG-1:0]   rt;
    logic [NB_REG-1:0]   exReg;
    logic                exWe;
    logic                exMr;
    logic [NB_REG-1:0]   memReg;
    logic                memWe;
    logic                memMr;
    logic                stall;
    logic                bubble;
    logic                flush;
    logic [NB_COUNT-1:0] stallCount;

    branch_hazard_controller #(
        .NB_REG   (NB_REG),
        .NB_COUNT (NB_COUNT)
    ) dut (
        .clock_i         (clk),
        .reset_n_i       (resetN),
        .enable_i        (enable),
        .ID_branch_i     (branch),
        .ID_taken_i      (taken),
        .ID_rs_i         (rs),
        .ID_rt_i         (rt),
        .EX_write_reg_i  (exReg),
        .EX_reg_write_i  (exWe),
        .EX_mem_read_i   (exMr),
        .MEM_write_reg_i (memReg),
        .MEM_reg_write_i (memWe),
        .MEM_mem_read_i  (memMr),
        .stall_o         (stall),
        .bubble_o        (bubble),
        .flush_o         (flush),
        .stall_count_o   (stallCount)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of the cycles still owed by a running stall
    // sequence, plus the expected counter value.
    typedef enum {SEQ_STALL, SEQ_RELEASE} seq_e;
    seq_e pending[$];
    int   mCount = 0;

    int stallSeen = 0;
    int flushSeen = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int expCnt(input int v);
`ifdef BRANCH_STALL_COUNTER_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic bit hits(input logic [NB_REG-1:0] dst, input logic we);
        return we && (dst != 0) && (rs == dst || rt == dst);
    endfunction

    // Stall cycles a branch must wait given the current EX/MEM contents.
    function automatic int hazardLen();
        if (!branch) return 0;
        if (hits(exReg, exWe)) return exMr ? 2 : 1;
        if (hits(memReg, memWe) && memMr) return 1;
        return 0;
    endfunction

    task automatic applyStimulus(input logic br, input logic tk,
                                 input logic [NB_REG-1:0] s, input logic [NB_REG-1:0] t,
                                 input logic [NB_REG-1:0] eR, input logic eW, input logic eM,
                                 input logic [NB_REG-1:0] mR, input logic mW, input logic mM);
        branch = br; taken = tk; rs = s; rt = t;
        exReg = eR; exWe = eW; exMr = eM;
        memReg = mR; memWe = mW; memMr = mM;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic runCycle(input string tag);
        bit expStall;
        bit expFlush;
        int len;
        @(negedge clk);
        expStall = 0;
        expFlush = 0;
        len      = hazardLen();
        if (resetN) begin
            if (!enable) begin
                expStall = pending.size() > 0;
            end else if (pending.size() > 0) begin
                expStall = (pending[0] == SEQ_STALL);
            end else begin
                expStall = len > 0;
                expFlush = branch && taken && (len == 0);
            end
        end
        checkOutput({tag, ".stall"},  32'(stall),      32'(expStall));
        checkOutput({tag, ".bubble"}, 32'(bubble),     32'(expStall));
        checkOutput({tag, ".flush"},  32'(flush),      32'(expFlush));
        checkOutput({tag, ".count"},  32'(stallCount), 32'(expCnt(mCount)));
        stallSeen += int'(stall);
        flushSeen += int'(flush);
        @(posedge clk);
        if (!resetN) begin
            pending.delete();
            mCount = 0;
        end else if (enable) begin
            if (expStall && mCount < CNT_MAX) mCount++;
            if (pending.size() > 0) begin
                void'(pending.pop_front());
            end else if (len == 2) begin
                pending.push_back(SEQ_STALL);
                pending.push_back(SEQ_RELEASE);
            end else if (len == 1) begin
                pending.push_back(SEQ_RELEASE);
            end
        end
        #1;
    endtask

    task automatic clearStats();
        stallSeen = 0;
        flushSeen = 0;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("reset");
        runCycle("reset");
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0;
        enable = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        doReset();
        checkOutput("reset.countAfter", 32'(stallCount), 0);

        // lw $3 in EX, beq $3,$4 taken
        clearStats();
        applyStimulus(1, 1, 3, 4, 3, 1, 1, 0, 0, 0);
        runCycle("lw_beq");
        applyStimulus(1, 1, 3, 4, 0, 0, 0, 0, 0, 0);
        runCycle("lw_beq");
        runCycle("lw_beq");
        runCycle("lw_beq");
        checkOutput("lw_beq.stallCycles", 32'(stallSeen), 2);
        checkOutput("lw_beq.flushCycles", 32'(flushSeen), 1);
        checkOutput("lw_beq.countTotal",  32'(stallCount), 32'(expCnt(2)));

        // add $5 in EX, bne $5,$0 not taken
        clearStats();
        applyStimulus(1, 0, 5, 0, 5, 1, 0, 0, 0, 0);
        runCycle("add_bne");
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        runCycle("add_bne");
        runCycle("add_bne");
        checkOutput("add_bne.stallCycles", 32'(stallSeen), 1);
        checkOutput("add_bne.flushCycles", 32'(flushSeen), 0);

        // lw $0 in EX, beq $0,$0 taken: never hazardous
        clearStats();
        applyStimulus(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        runCycle("zero_reg");
        checkOutput("zero_reg.stallCycles", 32'(stallSeen), 0);
        checkOutput("zero_reg.flushCycles", 32'(flushSeen), 1);

        // add $7 in MEM is forwarded; lw $7 in MEM costs one cycle
        clearStats();
        applyStimulus(1, 0, 7, 1, 0, 0, 0, 7, 1, 0);
        runCycle("mem_add");
        checkOutput("mem_add.stallCycles", 32'(stallSeen), 0);
        clearStats();
        applyStimulus(1, 0, 7, 1, 0, 0, 0, 7, 1, 1);
        runCycle("mem_lw");
        applyStimulus(1, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        runCycle("mem_lw");
        checkOutput("mem_lw.stallCycles", 32'(stallSeen), 1);

        // reset while in STALL_2
        applyStimulus(1, 1, 3, 4, 3, 1, 1, 0, 0, 0);
        runCycle("rst_mid");
        resetN = 1'b0;
        runCycle("rst_mid");
        resetN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clearStats();
        runCycle("rst_mid");
        checkOutput("rst_mid.stallCycles", 32'(stallSeen), 0);
        checkOutput("rst_mid.count", 32'(stallCount), 0);

        // debug freeze during STALL_1
        clearStats();
        applyStimulus(1, 1, 5, 2, 5, 1, 0, 0, 0, 0);
        runCycle("freeze");
        applyStimulus(1, 1, 5, 2, 0, 0, 0, 0, 0, 0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) runCycle("freeze");
        checkOutput("freeze.countHeld", 32'(stallCount), 32'(expCnt(1)));
        enable = 1'b1;
        runCycle("freeze");
        runCycle("freeze");
        checkOutput("freeze.stallCycles", 32'(stallSeen), 4);
        checkOutput("freeze.flushCycles", 32'(flushSeen), 1);

        // saturation of the counter
        doReset();
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            applyStimulus(1, 0, 6, 1, 6, 1, 0, 0, 0, 0);
            runCycle("sat");
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            runCycle("sat");
        end
        checkOutput("sat.count", 32'(stallCount), 32'(expCnt(CNT_MAX)));

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            resetN = ($urandom_range(0, 79) != 0);
            enable = ($urandom_range(0, 6) != 0);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          NB_REG'($urandom_range(0, 7)), NB_REG'($urandom_range(0, 7)),
                          NB_REG'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          NB_REG'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            runCycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
